// File: rtl/acc_result_reader_pkg.sv
// acc_pkg: shared constants for the accelerator result readback block.
//   - register word addresses on the Avalon slave port
//   - bit positions inside STATUS, DATA and RESULT read words
//   - writedata bit that requests a flush
package acc_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_DATA   = 3'd1;
  localparam logic [2:0] ADDR_RESULT = 3'd2;

  localparam int unsigned ST_EMPTY_BIT     = 8;
  localparam int unsigned ST_FULL_BIT      = 9;
  localparam int unsigned ST_DONE_BIT      = 10;
  localparam int unsigned ST_UNDERFLOW_BIT = 11;

  localparam int unsigned DATA_VALID_BIT   = 8;
  localparam int unsigned RES_MAX_LSB      = 8;
  localparam int unsigned RES_VALID_BIT    = 16;

  localparam int unsigned FLUSH_BIT        = 0;

endpackage

// File: rtl/acc_result_reader_if.sv
// acc_result_reader_if: result stream from the dense layer plus the Avalon-MM
// slave register port used by the HPS.
//   stream : in_valid, in_data[DW-1:0], in_last (master -> slave), in_ready (slave -> master)
//   avalon : chipselect, read, write, address[2:0], writedata[31:0] (master -> slave),
//            readdata[31:0] (slave -> master)
interface acc_result_reader_if #(
  parameter int unsigned DW = 8
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;

  logic          chipselect;
  logic          read;
  logic          write;
  logic [2:0]    address;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output in_valid, in_data, in_last,
    output chipselect, read, write, address, writedata,
    input  in_ready, readdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    input  chipselect, read, write, address, writedata,
    output in_ready, readdata
  );

endinterface

// File: rtl/acc_result_reader_result_fifo.sv
// result_fifo: synchronous FIFO of DEPTH (power of two) entries, DW bits wide.
//   clk, reset (async active-low), flush (sync clear, dominates push/pop),
//   push/wr_data, pop, rd_data (head, combinational), count (0..DEPTH), full, empty.
// Push is ignored when full and pop when empty, so callers may drive raw strobes.
module result_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acc_result_reader.sv
// acc_result_reader: buffers signed result elements from the dense layer,
// tracks the per-frame argmax and serves both to the HPS over Avalon-MM.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : stream input + Avalon slave (acc_result_reader_if.slave)
//   done   : sticky frame-complete flag, cleared by flush or reset
// Register map: 0 STATUS, 1 DATA (pops head), 2 RESULT, 3-7 read as zero.
// DW is expected to be at most 8 so that fields line up with the register map.
module acc_result_reader
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  acc_result_reader_if.slave   bus,
  output logic                 done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

  logic          rd_strobe;
  logic          wr_strobe;
  logic          flush;
  logic          push_acc;
  logic          pop;
  logic [DW-1:0] head;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [7:0]    count8;

  logic [31:0]   readdata_q;
  logic [31:0]   rd_mux;
  logic          underflow;

  logic [DW-1:0] run_max;
  logic [7:0]    best_idx;
  logic [7:0]    idx_cnt;
  logic [DW-1:0] res_max;
  logic [7:0]    res_idx;
  logic          res_valid;

  logic          gt;
  logic [DW-1:0] new_max;
  logic [7:0]    new_best;

  assign rd_strobe = bus.chipselect && bus.read;
  assign wr_strobe = bus.chipselect && bus.write;
  assign flush     = wr_strobe && (bus.address == ADDR_STATUS) && bus.writedata[FLUSH_BIT];
  assign bus.in_ready = !full;
  // Flush dominates a coincident push: the element and its in_last are dropped.
  assign push_acc  = bus.in_valid && !full && !flush;
  assign pop       = rd_strobe && (bus.address == ADDR_DATA) && !empty;
  assign count8    = 8'(count);
  assign bus.readdata = readdata_q;

  result_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (push_acc),
    .wr_data (bus.in_data),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Strictly-greater compare keeps the first maximum on ties.
  always_comb begin
    gt       = $signed(bus.in_data) > $signed(run_max);
    new_max  = gt ? bus.in_data : run_max;
    new_best = gt ? idx_cnt : best_idx;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_STATUS: begin
        rd_mux[7:0]              = count8;
        rd_mux[ST_EMPTY_BIT]     = empty;
        rd_mux[ST_FULL_BIT]      = full;
        rd_mux[ST_DONE_BIT]      = done;
        rd_mux[ST_UNDERFLOW_BIT] = underflow;
      end
      ADDR_DATA: begin
        if (!empty) begin
          rd_mux[DW-1:0]         = head;
          rd_mux[DATA_VALID_BIT] = 1'b1;
        end
      end
      ADDR_RESULT: begin
        rd_mux[7:0]                = res_idx;
        rd_mux[RES_MAX_LSB +: DW]  = res_max;
        rd_mux[RES_VALID_BIT]      = res_valid;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_q <= '0;
      done       <= 1'b0;
      underflow  <= 1'b0;
      run_max    <= MIN_VAL;
      best_idx   <= '0;
      idx_cnt    <= '0;
      res_max    <= '0;
      res_idx    <= '0;
      res_valid  <= 1'b0;
    end else begin
      // readdata samples pre-write state, so a same-cycle flush is not visible.
      if (rd_strobe) readdata_q <= rd_mux;

      if (flush) begin
        done      <= 1'b0;
        underflow <= 1'b0;
        run_max   <= MIN_VAL;
        best_idx  <= '0;
        idx_cnt   <= '0;
        res_max   <= '0;
        res_idx   <= '0;
        res_valid <= 1'b0;
      end else begin
        if (rd_strobe && (bus.address == ADDR_DATA) && empty) underflow <= 1'b1;

        if (push_acc) begin
          if (bus.in_last) begin
            res_max   <= new_max;
            res_idx   <= new_best;
            res_valid <= 1'b1;
            done      <= 1'b1;
            run_max   <= MIN_VAL;
            best_idx  <= '0;
            idx_cnt   <= '0;
          end else begin
            run_max   <= new_max;
            best_idx  <= new_best;
            idx_cnt   <= (idx_cnt == 8'hFF) ? idx_cnt : idx_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_result_reader.sv
// tb_acc_result_reader: directed self-checking bench for acc_result_reader
// (DEPTH=16, DW=8) with hand-computed expected register values.
module tb_acc_result_reader;

  logic clk;
  logic reset;
  logic done;

  int unsigned tests;
  int unsigned fails;
  logic [31:0] rd;

  acc_result_reader_if #(.DW(8)) bus ();

  acc_result_reader #(.DEPTH(16), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    tick();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    d = bus.readdata;
  endtask

  task automatic push(input logic [7:0] v, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_flush();
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h1;
    tick();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0;

    // Reset state
    #2 reset = 1'b0;
    tick(); tick();
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    tick();
    reg_read(3'd0, rd); check("rst_status", rd, 32'h100);

    // Frame 5,-3,17,17,2: first 17 (index 2) wins the tie
    push(8'd5, 1'b0); push(8'hFD, 1'b0); push(8'd17, 1'b0);
    push(8'd17, 1'b0); push(8'd2, 1'b1);
    reg_read(3'd0, rd); check("frame_status", rd, 32'h405);
    reg_read(3'd2, rd); check("frame_result", rd, 32'h11102);
    check("frame_done", {31'd0, done}, 32'd1);
    reg_read(3'd5, rd); check("unmapped_addr5", rd, 32'h0);

    // Fill to full, refused push, pop while push held
    do_flush();
    check("flush_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    reg_read(3'd0, rd); check("full_status", rd, 32'h210);
    reg_read(3'd1, rd); check("full_pop_data", rd, 32'h100);
    bus.in_valid = 1'b0;
    check("after_pop_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reg_read(3'd0, rd); check("after_pop_status", rd, 32'h00F);
    reg_read(3'd1, rd); check("after_pop_next", rd, 32'h101);

    // Drain past empty: underflow
    do_flush();
    push(8'h7F, 1'b0); push(8'h80, 1'b0); push(8'h01, 1'b0);
    reg_read(3'd1, rd); check("drain0", rd, 32'h17F);
    reg_read(3'd1, rd); check("drain1", rd, 32'h180);
    reg_read(3'd1, rd); check("drain2", rd, 32'h101);
    reg_read(3'd1, rd); check("drain3", rd, 32'h000);
    reg_read(3'd1, rd); check("drain4", rd, 32'h000);
    reg_read(3'd0, rd); check("underflow_status", rd, 32'h900);

    // Flush coinciding with a last element
    do_flush();
    push(8'h30, 1'b1);
    push(8'h40, 1'b0);
    check("pre_flush_done", {31'd0, done}, 32'd1);
    bus.in_valid = 1'b1; bus.in_data = 8'h7F; bus.in_last = 1'b1;
    do_flush();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("flush_push_done", {31'd0, done}, 32'd0);
    reg_read(3'd0, rd); check("flush_push_status", rd, 32'h100);
    reg_read(3'd2, rd); check("flush_push_result", rd, 32'h0);
    push(8'h05, 1'b1);
    reg_read(3'd2, rd); check("post_flush_result", rd, 32'h10500);

    // Asynchronous reset mid-frame
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_readdata", bus.readdata, 32'h0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reg_read(3'd0, rd); check("post_rst_status", rd, 32'h100);
    reg_read(3'd2, rd); check("post_rst_result", rd, 32'h0);
    push(8'hFF, 1'b0); push(8'hFB, 1'b1);
    reg_read(3'd2, rd); check("post_rst_argmax", rd, 32'h1FF00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
